alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execution end of the RS->ALU dispatch interface: accepts one integer op per cycle from the
//  reservation station, computes result and branch/jump outcome, and buffers results in a
//  small FIFO that drains onto the common data bus (CDB) under an arbiter valid/grant handshake.
//  Back-pressures the RS with alu_full.
// PARAMETERS
//  ROB_W    4   ROB index width
//  Q_DEPTH  4   result FIFO entries (power of two, >=2)
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      synchronous reset, ACTIVE-LOW
//  rdy            in   1      global enable; when 0 all state holds
//  rollback       in   1      mispredict flush
//  alu_en         in   1      dispatch valid (one op per cycle)
//  alu_rob_pos    in   ROB_W  destination ROB entry
//  alu_opcode     in   7      RV32I opcode
//  alu_funct3     in   3      funct3
//  alu_funct7     in   1      instr[30]
//  alu_val1       in   32     rs1 value
//  alu_val2       in   32     rs2 value
//  alu_imm        in   32     sign-extended immediate
//  alu_pc         in   32     instruction PC
//  alu_full       out  1      RS must not dispatch next cycle
//  cdb_valid      out  1      FIFO head valid
//  cdb_rob_pos    out  ROB_W  head ROB index
//  cdb_res        out  32     head result (rd value)
//  cdb_jump       out  1      head is taken branch / jump
//  cdb_target     out  32     head redirect PC
//  cdb_grant      in   1      arbiter accepts head this cycle
// BEHAVIOUR
//  Reset (rst==0 at edge): FIFO empty, head/tail/count=0; cdb_valid=0, cdb_* data=0, alu_full=0.
//  Decode (combinational on inputs): OP 0110011 / OP-IMM 0010011: ADD/SUB(funct7=1, OP only),
//   SLL, SLT, SLTU, XOR, SRL/SRA(funct7), OR, AND; op2=val2 for OP, imm for OP-IMM; shift
//   amount = op2[4:0]. LUI: res=imm. AUIPC: res=pc+imm. JAL: res=pc+4, jump=1,
//   target=pc+imm. JALR: res=pc+4, jump=1, target=(val1+imm)&~1. BRANCH 1100011:
//   BEQ/BNE/BLT/BGE/BLTU/BGEU on val1,val2; res=0; target=pc+imm if taken else pc+4,
//   jump=taken. Other opcodes: res=0, jump=0, still enqueued. All arithmetic mod 2^32.
//  Latency: alu_en at cycle N -> entry written at edge ending N -> cdb_valid=1 in N+1 if FIFO
//   was empty. One op/cycle sustained while cdb_grant held high.
//  Handshake: cdb_* driven from FIFO head registers; stable while cdb_valid && !cdb_grant.
//   Head pops on edge with cdb_valid && cdb_grant. cdb_grant while !cdb_valid ignored.
//  Simultaneous push+pop: count unchanged; push into full FIFO with pop allowed.
//  alu_full = (count >= Q_DEPTH-1), registered-from-count; guarantees room for the one op
//   already in flight. Push while count==Q_DEPTH and no pop: dropped (protocol error, assert).
//  Pointers wrap modulo Q_DEPTH.
//  rollback (rdy=1): FIFO cleared, same-cycle alu_en op discarded, cdb_valid=0 next cycle;
//   a same-cycle grant is irrelevant (entry flushed either way).
//  rdy=0: no push, no pop, outputs hold; alu_en/cdb_grant ignored.
//  Reset has priority over rollback; rollback over push/pop.
// TESTING
//  ADDI: val1=5,imm=-3,rob=2,grant=1 -> next cycle cdb_valid=1,res=2,rob=2,jump=0.
//  SRA: val1=0x80000000,val2=4,funct7=1 -> res=0xF8000000; SRL same -> 0x08000000.
//  BLT: pc=0x100,val1=-1,val2=1,imm=0x20 -> jump=1,target=0x120; BLTU same -> jump=0,target=0x104.
//  grant=0, 3 ops -> alu_full=1 after 3rd; 4th push still accepted; grant resumes -> FIFO order kept.
//  FIFO holding 2 entries + alu_en, rollback=1 -> next cycle cdb_valid=0, count=0.
//  rst=0 mid-stream with rdy=0 -> cdb_valid=0, alu_full=0 after edge; rdy=0 alone holds all outputs.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execute stage fed by the reservation station: decodes and computes one RV32I op per
// cycle and queues the results in a small FIFO that drains onto the CDB under valid/grant.
module alu_exec_unit #(
  parameter int ROB_W   = 4,
  parameter int Q_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             alu_en,
  input  logic [ROB_W-1:0] alu_rob_pos,
  input  logic [6:0]       alu_opcode,
  input  logic [2:0]       alu_funct3,
  input  logic             alu_funct7,
  input  logic [31:0]      alu_val1,
  input  logic [31:0]      alu_val2,
  input  logic [31:0]      alu_imm,
  input  logic [31:0]      alu_pc,
  output logic             alu_full,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_pos,
  output logic [31:0]      cdb_res,
  output logic             cdb_jump,
  output logic [31:0]      cdb_target,
  input  logic             cdb_grant
);

  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [31:0]      res;
    logic             jump;
    logic [31:0]      target;
  } entry_t;

  entry_t            mem_q [Q_DEPTH];
  entry_t            head_ent_q, head_ent_d;
  entry_t            new_ent;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_inc;
  logic [CNT_W-1:0]  count_q, count_d, count_after_pop;
  logic              valid_q, valid_d, full_q, full_d;
  logic              pop, push;

  logic [31:0] op2;
  logic [4:0]  shamt;
  logic        taken;

  // Decode and execute the incoming op.
  always_comb begin
    new_ent     = '0;
    new_ent.rob = alu_rob_pos;
    op2         = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
    shamt       = op2[4:0];
    taken       = 1'b0;
    case (alu_opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (alu_funct3)
          3'b000:  new_ent.res = (alu_opcode == OPC_OP && alu_funct7) ? alu_val1 - op2
                                                                      : alu_val1 + op2;
          3'b001:  new_ent.res = alu_val1 << shamt;
          3'b010:  new_ent.res = {31'b0, $signed(alu_val1) < $signed(op2)};
          3'b011:  new_ent.res = {31'b0, alu_val1 < op2};
          3'b100:  new_ent.res = alu_val1 ^ op2;
          3'b101:  new_ent.res = alu_funct7 ? $unsigned($signed(alu_val1) >>> shamt)
                                            : alu_val1 >> shamt;
          3'b110:  new_ent.res = alu_val1 | op2;
          default: new_ent.res = alu_val1 & op2;
        endcase
      end
      OPC_LUI:   new_ent.res = alu_imm;
      OPC_AUIPC: new_ent.res = alu_pc + alu_imm;
      OPC_JAL: begin
        new_ent.res    = alu_pc + 32'd4;
        new_ent.jump   = 1'b1;
        new_ent.target = alu_pc + alu_imm;
      end
      OPC_JALR: begin
        new_ent.res    = alu_pc + 32'd4;
        new_ent.jump   = 1'b1;
        new_ent.target = (alu_val1 + alu_imm) & ~32'd1;
      end
      OPC_BRANCH: begin
        case (alu_funct3)
          3'b000:  taken = (alu_val1 == alu_val2);
          3'b001:  taken = (alu_val1 != alu_val2);
          3'b100:  taken = ($signed(alu_val1) <  $signed(alu_val2));
          3'b101:  taken = ($signed(alu_val1) >= $signed(alu_val2));
          3'b110:  taken = (alu_val1 <  alu_val2);
          3'b111:  taken = (alu_val1 >= alu_val2);
          default: taken = 1'b0;
        endcase
        new_ent.jump   = taken;
        new_ent.target = taken ? alu_pc + alu_imm : alu_pc + 32'd4;
      end
      default: ;
    endcase
  end

  // FIFO control; the head entry is kept in its own register so the CDB sees a registered copy.
  always_comb begin
    pop             = rdy & ~rollback & valid_q & cdb_grant;
    push            = rdy & ~rollback & alu_en & ((count_q != CNT_W'(Q_DEPTH)) | pop);
    head_inc        = head_q + PTR_W'(1);
    count_after_pop = count_q - CNT_W'(pop);
    head_d          = pop  ? head_inc : head_q;
    tail_d          = push ? tail_q + PTR_W'(1) : tail_q;
    count_d         = count_after_pop + CNT_W'(push);
    head_ent_d      = head_ent_q;
    if (push && count_after_pop == '0) begin
      head_ent_d = new_ent;
    end else if (pop) begin
      head_ent_d = mem_q[head_inc];
    end
    if (rdy && rollback) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    valid_d = (count_d != '0);
    full_d  = (count_d >= CNT_W'(Q_DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      head_ent_q <= '0;
    end else if (rdy) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      head_ent_q <= head_ent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[tail_q] <= new_ent;
    end
  end

  // The RS honours alu_full, so a push into a full FIFO without a pop is a protocol error.
  always_ff @(posedge clk) begin
    if (rst && rdy && !rollback && alu_en && count_q == CNT_W'(Q_DEPTH) && !pop) begin
      assert (1'b0) else $error("alu_exec_unit: dispatch into full result FIFO dropped");
    end
  end

  assign alu_full    = full_q;
  assign cdb_valid   = valid_q;
  assign cdb_rob_pos = head_ent_q.rob;
  assign cdb_res     = head_ent_q.res;
  assign cdb_jump    = head_ent_q.jump;
  assign cdb_target  = head_ent_q.target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, FIFO corner sequences, then random traffic
// against a queue-based reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, alu_en, alu_funct7, cdb_grant;
  logic [3:0]  alu_rob_pos;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic        alu_full, cdb_valid, cdb_jump;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_res, cdb_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.ROB_W(4), .Q_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_rob_pos(alu_rob_pos), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_full(alu_full), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos),
    .cdb_res(cdb_res), .cdb_jump(cdb_jump), .cdb_target(cdb_target), .cdb_grant(cdb_grant)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2, imm, pc;
    logic [31:0] res;
    logic        jump;
    logic [31:0] tgt;
    logic        chk_tgt;
  } vec_t;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] res;
    logic        jump;
    logic [31:0] tgt;
    logic        chk_tgt;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [3:0] rob);
    alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
  endtask

  // Reference: RV32I semantics written directly from the instruction rules.
  function automatic ent_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] rob);
    ent_t e;
    logic [31:0] b;
    int sh;
    logic t;
    e = '{rob: rob, res: 32'd0, jump: 1'b0, tgt: 32'd0, chk_tgt: 1'b0};
    b = (op == 7'h33) ? v2 : imm;
    sh = int'(b[4:0]);
    t = 1'b0;
    if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        3'd0: e.res = (op == 7'h33 && f7) ? v1 - b : v1 + b;
        3'd1: e.res = v1 << sh;
        3'd2: e.res = ($signed(v1) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: e.res = (v1 < b) ? 32'd1 : 32'd0;
        3'd4: e.res = v1 ^ b;
        3'd5: begin
          e.res = v1 >> sh;
          if (f7 && v1[31]) e.res = e.res | ~(32'hFFFF_FFFF >> sh);
        end
        3'd6: e.res = v1 | b;
        default: e.res = v1 & b;
      endcase
    end else if (op == 7'h37) begin
      e.res = imm;
    end else if (op == 7'h17) begin
      e.res = pc + imm;
    end else if (op == 7'h6F || op == 7'h67) begin
      e.res = pc + 4;
      e.jump = 1'b1;
      e.tgt = (op == 7'h6F) ? pc + imm : {v1 + imm} & 32'hFFFF_FFFE;
      e.chk_tgt = 1'b1;
    end else if (op == 7'h63) begin
      case (f3)
        3'd0: t = (v1 == v2);
        3'd1: t = (v1 != v2);
        3'd4: t = ($signed(v1) < $signed(v2));
        3'd5: t = !($signed(v1) < $signed(v2));
        3'd6: t = (v1 < v2);
        3'd7: t = !(v1 < v2);
        default: t = 1'b0;
      endcase
      e.jump = t;
      e.tgt = t ? pc + imm : pc + 4;
      e.chk_tgt = 1'b1;
    end
    return e;
  endfunction

  vec_t vecs[16];
  logic [6:0] ops[8];

  initial begin
    ent_t e;
    logic [6:0] rop;
    logic [31:0] rv1, rv2;
    logic rrdy, rrb, ren, rgnt;

    vecs[0]  = '{7'h13, 3'd0, 1'b0, 32'd5,        32'd0,        32'hFFFF_FFFD, 32'h0,     32'd2,        1'b0, 32'h0,   1'b0};
    vecs[1]  = '{7'h33, 3'd5, 1'b1, 32'h8000_0000, 32'd4,       32'd0,         32'h0,     32'hF800_0000, 1'b0, 32'h0,  1'b0};
    vecs[2]  = '{7'h33, 3'd5, 1'b0, 32'h8000_0000, 32'd4,       32'd0,         32'h0,     32'h0800_0000, 1'b0, 32'h0,  1'b0};
    vecs[3]  = '{7'h63, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'h20,        32'h100,   32'd0,        1'b1, 32'h120, 1'b1};
    vecs[4]  = '{7'h63, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'h20,        32'h100,   32'd0,        1'b0, 32'h104, 1'b1};
    vecs[5]  = '{7'h33, 3'd0, 1'b1, 32'd3,        32'd5,        32'd0,         32'h0,     32'hFFFF_FFFE, 1'b0, 32'h0,  1'b0};
    vecs[6]  = '{7'h13, 3'd0, 1'b1, 32'd3,        32'd0,        32'd5,         32'h0,     32'd8,        1'b0, 32'h0,   1'b0};
    vecs[7]  = '{7'h37, 3'd0, 1'b0, 32'd9,        32'd9,        32'h1234_5000, 32'h0,     32'h1234_5000, 1'b0, 32'h0,  1'b0};
    vecs[8]  = '{7'h17, 3'd0, 1'b0, 32'd0,        32'd0,        32'h2000,      32'h1000,  32'h3000,     1'b0, 32'h0,   1'b0};
    vecs[9]  = '{7'h6F, 3'd0, 1'b0, 32'd0,        32'd0,        32'hFFFF_FFF0, 32'h200,   32'h204,      1'b1, 32'h1F0, 1'b1};
    vecs[10] = '{7'h67, 3'd0, 1'b0, 32'h301,      32'd0,        32'h4,         32'h40,    32'h44,       1'b1, 32'h304, 1'b1};
    vecs[11] = '{7'h63, 3'd0, 1'b0, 32'd7,        32'd7,        32'h10,        32'h80,    32'd0,        1'b1, 32'h90,  1'b1};
    vecs[12] = '{7'h63, 3'd7, 1'b0, 32'd1,        32'hFFFF_FFFF, 32'h10,       32'h80,    32'd0,        1'b0, 32'h84,  1'b1};
    vecs[13] = '{7'h33, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,         32'h0,     32'd1,        1'b0, 32'h0,   1'b0};
    vecs[14] = '{7'h13, 3'd1, 1'b0, 32'd1,        32'd0,        32'h25,        32'h0,     32'h20,       1'b0, 32'h0,   1'b0};
    vecs[15] = '{7'h7F, 3'd0, 1'b0, 32'd1,        32'd2,        32'd3,         32'h4,     32'd0,        1'b0, 32'h0,   1'b0};
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0B};

    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0; cdb_grant = 1'b0;
    set_op(7'h0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    tick(); tick();
    chk("reset_valid", 32'(cdb_valid), 32'd0);
    chk("reset_full", 32'(alu_full), 32'd0);
    chk("reset_res", cdb_res, 32'd0);
    chk("reset_rob", 32'(cdb_rob_pos), 32'd0);
    chk("reset_jump", 32'(cdb_jump), 32'd0);
    chk("reset_target", cdb_target, 32'd0);
    rst = 1'b1;

    // Directed vector table: one op, observed the next cycle, then popped.
    for (int i = 0; i < 16; i++) begin
      set_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].v1, vecs[i].v2, vecs[i].imm,
             vecs[i].pc, 4'(i));
      alu_en = 1'b1; cdb_grant = 1'b1;
      tick();
      alu_en = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(cdb_valid), 32'd1);
      chk($sformatf("vec%0d_rob", i), 32'(cdb_rob_pos), 32'(i));
      chk($sformatf("vec%0d_res", i), cdb_res, vecs[i].res);
      chk($sformatf("vec%0d_jump", i), 32'(cdb_jump), 32'(vecs[i].jump));
      if (vecs[i].chk_tgt) chk($sformatf("vec%0d_target", i), cdb_target, vecs[i].tgt);
      tick();
      chk($sformatf("vec%0d_drained", i), 32'(cdb_valid), 32'd0);
    end

    // Back-pressure: fill with grant low, then drain in order.
    cdb_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_op(7'h13, 3'd0, 1'b0, 32'(k * 10), 32'd0, 32'd1, 32'd0, 4'(k));
      alu_en = 1'b1;
      tick();
      chk($sformatf("fill%0d_full", k), 32'(alu_full), (k >= 2) ? 32'd1 : 32'd0);
    end
    alu_en = 1'b0; cdb_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(cdb_valid), 32'd1);
      chk($sformatf("drain%0d_rob", k), 32'(cdb_rob_pos), 32'(k));
      chk($sformatf("drain%0d_res", k), cdb_res, 32'(k * 10 + 1));
      chk($sformatf("drain%0d_full", k), 32'(alu_full), (4 - k >= 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("drain_empty", 32'(cdb_valid), 32'd0);

    // Rollback with two queued entries and a same-cycle dispatch.
    cdb_grant = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      set_op(7'h13, 3'd0, 1'b0, 32'(k), 32'd0, 32'd0, 32'd0, 4'(k));
      alu_en = 1'b1;
      tick();
    end
    set_op(7'h13, 3'd0, 1'b0, 32'd3, 32'd0, 32'd0, 32'd0, 4'd3);
    rollback = 1'b1;
    tick();
    rollback = 1'b0; alu_en = 1'b0;
    chk("rollback_valid", 32'(cdb_valid), 32'd0);
    chk("rollback_full", 32'(alu_full), 32'd0);
    for (int k = 5; k <= 7; k++) begin
      set_op(7'h13, 3'd0, 1'b0, 32'(k * 3), 32'd0, 32'd0, 32'd0, 4'(k));
      alu_en = 1'b1;
      tick();
    end
    alu_en = 1'b0;
    chk("post_rb_rob", 32'(cdb_rob_pos), 32'd5);
    chk("post_rb_res", cdb_res, 32'd15);
    chk("post_rb_full", 32'(alu_full), 32'd1);
    cdb_grant = 1'b1;
    tick(); tick(); tick();
    chk("post_rb_drained", 32'(cdb_valid), 32'd0);

    // rdy=0 freezes everything; reset still applies while rdy=0.
    cdb_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(7'h13, 3'd0, 1'b0, 32'(100 * (k + 1)), 32'd0, 32'd0, 32'd0, 4'(7 + k));
      alu_en = 1'b1;
      tick();
    end
    rdy = 1'b0; cdb_grant = 1'b1;
    set_op(7'h13, 3'd0, 1'b0, 32'd55, 32'd0, 32'd0, 32'd0, 4'd1);
    tick(); tick();
    chk("hold_valid", 32'(cdb_valid), 32'd1);
    chk("hold_rob", 32'(cdb_rob_pos), 32'd7);
    chk("hold_res", cdb_res, 32'd100);
    chk("hold_full", 32'(alu_full), 32'd1);
    alu_en = 1'b0; cdb_grant = 1'b0; rst = 1'b0;
    tick();
    chk("rst_norey_valid", 32'(cdb_valid), 32'd0);
    chk("rst_nordy_full", 32'(alu_full), 32'd0);
    chk("rst_nordy_res", cdb_res, 32'd0);
    rst = 1'b1; rdy = 1'b1;

    // Random traffic against the queue model; the bench acts as an RS that respects alu_full.
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", 32'(cdb_valid), (q.size() != 0) ? 32'd1 : 32'd0);
      chk("rnd_full", 32'(alu_full), (q.size() >= 3) ? 32'd1 : 32'd0);
      if (q.size() != 0) begin
        chk("rnd_rob", 32'(cdb_rob_pos), 32'(q[0].rob));
        chk("rnd_res", cdb_res, q[0].res);
        chk("rnd_jump", 32'(cdb_jump), 32'(q[0].jump));
        if (q[0].chk_tgt) chk("rnd_target", cdb_target, q[0].tgt);
      end
      rrdy = ($urandom_range(0, 7) != 0);
      rrb  = ($urandom_range(0, 19) == 0);
      ren  = (q.size() < 3) && ($urandom_range(0, 3) != 0);
      rgnt = ($urandom_range(0, 2) != 0);
      rop  = ops[$urandom_range(0, 7)];
      rv1  = $urandom;
      rv2  = ($urandom_range(0, 3) == 0) ? rv1 : $urandom;
      set_op(rop, 3'($urandom), 1'($urandom), rv1, rv2, $urandom, $urandom, 4'($urandom));
      rdy = rrdy; rollback = rrb; alu_en = ren; cdb_grant = rgnt;
      if (rrdy) begin
        if (rrb) begin
          q.delete();
        end else begin
          if (rgnt && q.size() != 0) void'(q.pop_front());
          if (ren) begin
            e = model(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm,
                      alu_pc, alu_rob_pos);
            q.push_back(e);
          end
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
